cacheline_mem_arbiter: RTL and testbench

//  Shares one physical-memory line port between the instruction side (prefetch unit, read-only) and
//  the data side (D-cache, read or writeback). Sits between prefetch/D-cache and pmem.

---
 rtl/cacheline_mem_arbiter_pkg.sv | 9 +
 rtl/cacheline_mem_arbiter_starve_ctr.sv | 36 +++
 rtl/cacheline_mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_cacheline_mem_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_mem_arbiter_pkg.sv
// rtl/cacheline_mem_arbiter_pkg.sv - shared types and constants for the line-port arbiter
package cacheline_mem_arbiter_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY, ARB_RESP} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} arb_owner_t;

    localparam logic [31:0] LINE_OFFSET_MASK = 32'hFFFF_FFE0;

endpackage

// File: rtl/cacheline_mem_arbiter_starve_ctr.sv
// rtl/cacheline_mem_arbiter_starve_ctr.sv - saturating count of D grants made while I waits
module arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign sat = (cnt_q == CW'(STARVE_LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !sat) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// rtl/cacheline_mem_arbiter.sv - shares one pmem line port between prefetch (I) and D-cache (D)
module cacheline_mem_arbiter
    import cacheline_mem_arbiter_pkg::*;
#(
    parameter int LINE_WIDTH   = 256,
    parameter int ADDR_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pre_read_a,
    input  logic [ADDR_WIDTH-1:0] pre_addr_a,
    output logic [LINE_WIDTH-1:0] arb_pre_rdata,
    output logic                  arb_pre_resp,
    input  logic                  d_read_b,
    input  logic                  d_write_b,
    input  logic [ADDR_WIDTH-1:0] d_addr_b,
    input  logic [LINE_WIDTH-1:0] d_wdata_b,
    output logic [LINE_WIDTH-1:0] arb_d_rdata,
    output logic                  arb_d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ADDR_WIDTH'(LINE_OFFSET_MASK);

    arb_state_t            state_q, state_d;
    arb_owner_t            owner_q, owner_d;
    logic                  pmem_read_q, pmem_read_d;
    logic                  pmem_write_q, pmem_write_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] pre_rdata_q, pre_rdata_d;
    logic [LINE_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  pre_resp_q, pre_resp_d;
    logic                  d_resp_q, d_resp_d;

    logic d_req;
    logic grant_d;
    logic grant_i;
    logic starve_sat;

    // D wins unless I has been passed over STARVE_LIMIT times in a row
    assign d_req   = d_read_b | d_write_b;
    assign grant_d = (state_q == ARB_IDLE) && d_req && !(starve_sat && pre_read_a);
    assign grant_i = (state_q == ARB_IDLE) && pre_read_a && !grant_d;

    arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve_ctr (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (grant_d && pre_read_a),
        .clr    (grant_i),
        .sat    (starve_sat)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        pmem_read_d  = pmem_read_q;
        pmem_write_d = pmem_write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        pre_rdata_d  = pre_rdata_q;
        d_rdata_d    = d_rdata_q;
        pre_resp_d   = 1'b0;
        d_resp_d     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (grant_d) begin
                    owner_d      = OWN_D;
                    pmem_write_d = d_write_b;
                    pmem_read_d  = !d_write_b;
                    addr_d       = d_addr_b & ADDR_MASK;
                    wdata_d      = d_wdata_b;
                    state_d      = ARB_BUSY;
                end else if (grant_i) begin
                    owner_d      = OWN_I;
                    pmem_write_d = 1'b0;
                    pmem_read_d  = 1'b1;
                    addr_d       = pre_addr_a & ADDR_MASK;
                    state_d      = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (pmem_resp) begin
                    pmem_read_d  = 1'b0;
                    pmem_write_d = 1'b0;
                    if (owner_q == OWN_D) begin
                        d_resp_d = 1'b1;
                        if (pmem_read_q) d_rdata_d = pmem_rdata;
                    end else begin
                        pre_resp_d  = 1'b1;
                        pre_rdata_d = pmem_rdata;
                    end
                    state_d = ARB_RESP;
                end
            end
            ARB_RESP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            owner_q      <= OWN_I;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            pre_rdata_q  <= '0;
            d_rdata_q    <= '0;
            pre_resp_q   <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            pmem_read_q  <= pmem_read_d;
            pmem_write_q <= pmem_write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            pre_rdata_q  <= pre_rdata_d;
            d_rdata_q    <= d_rdata_d;
            pre_resp_q   <= pre_resp_d;
            d_resp_q     <= d_resp_d;
        end
    end

    assign pmem_read     = pmem_read_q;
    assign pmem_write    = pmem_write_q;
    assign pmem_address  = addr_q;
    assign pmem_wdata    = wdata_q;
    assign arb_pre_rdata = pre_rdata_q;
    assign arb_d_rdata   = d_rdata_q;
    assign arb_pre_resp  = pre_resp_q;
    assign arb_d_resp    = d_resp_q;

endmodule

// File: tb/tb_cacheline_mem_arbiter.sv
// tb/tb_cacheline_mem_arbiter.sv - randomized self-checking bench against a transaction-level model
module tb_cacheline_mem_arbiter;

    localparam int LW  = 256;
    localparam int AW  = 32;
    localparam int LIM = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          pre_read_a;
    logic [AW-1:0] pre_addr_a;
    logic [LW-1:0] arb_pre_rdata;
    logic          arb_pre_resp;
    logic          d_read_b;
    logic          d_write_b;
    logic [AW-1:0] d_addr_b;
    logic [LW-1:0] d_wdata_b;
    logic [LW-1:0] arb_d_rdata;
    logic          arb_d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    always #5 clk = ~clk;

    cacheline_mem_arbiter #(
        .LINE_WIDTH  (LW),
        .ADDR_WIDTH  (AW),
        .STARVE_LIMIT(LIM)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pre_read_a   (pre_read_a),
        .pre_addr_a   (pre_addr_a),
        .arb_pre_rdata(arb_pre_rdata),
        .arb_pre_resp (arb_pre_resp),
        .d_read_b     (d_read_b),
        .d_write_b    (d_write_b),
        .d_addr_b     (d_addr_b),
        .d_wdata_b    (d_wdata_b),
        .arb_d_rdata  (arb_d_rdata),
        .arb_d_resp   (arb_d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    int errors = 0;
    int checks = 0;

    // model state: what each requester should hold and how often I has been bypassed
    logic [LW-1:0] exp_pre_rdata;
    logic [LW-1:0] exp_d_rdata;
    int            starve;
    int            obs_winner;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        logic [LW-1:0] v;
        for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic check_quiet(input string tag);
        chk({tag, "_strobes_resps"}, {pmem_read, pmem_write, arb_pre_resp, arb_d_resp}, '0);
        chk({tag, "_pre_rdata"}, arb_pre_rdata, exp_pre_rdata);
        chk({tag, "_d_rdata"}, arb_d_rdata, exp_d_rdata);
    endtask

    // Entered at a negedge with the arbiter idle; ends at the negedge of the following idle cycle.
    task automatic run_round(input int lat, input logic [LW-1:0] rd, input bit withdraw);
        int            win;
        logic          d_pend;
        logic [AW-1:0] ea;
        logic          ew;
        logic [LW-1:0] ewd;
        d_pend = d_read_b | d_write_b;
        if (d_pend && !(pre_read_a && starve == LIM)) win = 2;
        else if (pre_read_a) win = 1;
        else win = 0;
        obs_winner = 0;
        if (win == 0) begin
            pmem_resp  = 1'b1;
            pmem_rdata = rd;
            @(negedge clk);
            pmem_resp = 1'b0;
            check_quiet("idle_spurious");
            return;
        end
        if (win == 2) begin
            if (d_read_b && d_write_b)
                $display("note: illegal d_read_b and d_write_b both set, expecting write");
            ea  = d_addr_b & ~32'h1F;
            ew  = d_write_b;
            ewd = d_wdata_b;
            if (pre_read_a) starve = (starve + 1 > LIM) ? LIM : starve + 1;
        end else begin
            ea  = pre_addr_a & ~32'h1F;
            ew  = 1'b0;
            ewd = '0;
            starve = 0;
        end
        for (int w = 1; w <= lat; w++) begin
            @(negedge clk);
            chk("pmem_read", pmem_read, !ew);
            chk("pmem_write", pmem_write, ew);
            chk("pmem_address", pmem_address, ea);
            if (ew) chk("pmem_wdata", pmem_wdata, ewd);
            chk("busy_no_resp", {arb_pre_resp, arb_d_resp}, '0);
            if (w == 1) begin
                if (win == 2) begin
                    d_addr_b  = $urandom();
                    d_wdata_b = rnd_line();
                    if (withdraw) begin d_read_b = 1'b0; d_write_b = 1'b0; end
                end else begin
                    pre_addr_a = $urandom();
                    if (withdraw) pre_read_a = 1'b0;
                end
            end
            if (w == lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rd;
            end
        end
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = rnd_line();
        if (!ew) begin
            if (win == 2) exp_d_rdata = rd;
            else exp_pre_rdata = rd;
        end
        obs_winner = arb_pre_resp ? 1 : (arb_d_resp ? 2 : 0);
        chk("arb_pre_resp", arb_pre_resp, win == 1);
        chk("arb_d_resp", arb_d_resp, win == 2);
        chk("arb_pre_rdata", arb_pre_rdata, exp_pre_rdata);
        chk("arb_d_rdata", arb_d_rdata, exp_d_rdata);
        chk("resp_strobes_low", {pmem_read, pmem_write}, '0);
        if (win == 2) begin d_read_b = 1'b0; d_write_b = 1'b0; end
        else pre_read_a = 1'b0;
        @(negedge clk);
        check_quiet("post_idle");
    endtask

    initial begin
        reset_n = 1'b0; pre_read_a = 1'b0; pre_addr_a = '0;
        d_read_b = 1'b0; d_write_b = 1'b0; d_addr_b = '0; d_wdata_b = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        exp_pre_rdata = '0; exp_d_rdata = '0; starve = 0; obs_winner = 0;
        repeat (2) @(negedge clk);
        check_quiet("reset");
        chk("reset_addr_wdata", {pmem_address, pmem_wdata[31:0]}, '0);
        reset_n = 1'b1;
        @(negedge clk);

        // lone I read with a 5-cycle memory latency
        pre_read_a = 1'b1;
        pre_addr_a = 32'h0000_0104;
        run_round(5, {32{8'hA5}}, 1'b0);
        chk("t1_winner", obs_winner, 1);

        // simultaneous I and D, then D kept busy so I must eventually be forced through
        pre_read_a = 1'b1;
        pre_addr_a = 32'h0000_0040;
        d_write_b  = 1'b1;
        d_addr_b   = 32'h0000_0080;
        d_wdata_b  = {8{32'h1234_5678}};
        for (int r = 0; r < 5; r++) begin
            run_round(2, rnd_line(), 1'b0);
            chk("t3_grant_order", obs_winner, (r == 4) ? 1 : 2);
            if (r < 4) begin
                d_read_b = 1'b1;
                d_addr_b = $urandom();
            end
        end
        pre_read_a = 1'b1;
        pre_addr_a = $urandom();
        run_round(1, rnd_line(), 1'b0);
        chk("t3_counter_cleared", obs_winner, 2);
        pre_read_a = 1'b0;
        run_round(1, rnd_line(), 1'b0);

        for (int n = 0; n < 300; n++) begin
            if (!pre_read_a && $urandom_range(0, 1) == 1) begin
                pre_read_a = 1'b1;
                pre_addr_a = $urandom();
            end
            if (!(d_read_b | d_write_b) && $urandom_range(0, 1) == 1) begin
                d_addr_b  = $urandom();
                d_wdata_b = rnd_line();
                if ($urandom_range(0, 15) == 0) begin
                    d_read_b = 1'b1; d_write_b = 1'b1;
                end else if ($urandom_range(0, 1) == 1) begin
                    d_write_b = 1'b1;
                end else begin
                    d_read_b = 1'b1;
                end
            end
            run_round($urandom_range(1, 4), rnd_line(), $urandom_range(0, 5) == 0);
        end

        // drain whatever is left, then abort a D read with reset
        pre_read_a = 1'b0; d_read_b = 1'b0; d_write_b = 1'b0;
        run_round(1, rnd_line(), 1'b0);
        d_read_b = 1'b1;
        d_addr_b = 32'h0000_0200;
        @(negedge clk);
        chk("t4_busy_read", pmem_read, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        exp_pre_rdata = '0;
        exp_d_rdata   = '0;
        starve        = 0;
        chk("t4_async_strobe_drop", {pmem_read, pmem_write}, '0);
        d_read_b = 1'b0;
        @(negedge clk);
        check_quiet("t4_in_reset");
        reset_n = 1'b1;
        @(negedge clk);
        check_quiet("t4_after_release");
        pre_read_a = 1'b1;
        pre_addr_a = 32'h0000_033F;
        run_round(3, rnd_line(), 1'b0);
        chk("t4_i_after_reset", obs_winner, 1);

        // spurious memory response with nothing outstanding
        run_round(1, rnd_line(), 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
